// File: rtl/tictactoe_pkg.sv
// Shared types and constants for the tic-tac-toe board engine.
// Board cells are row-major: cell = 3*row + col.
package tictactoe_pkg;

  localparam int CELLS = 9;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    W_NONE = 2'b00,
    W_X    = 2'b01,
    W_O    = 2'b10,
    W_DRAW = 2'b11
  } winner_t;

  // Rows 0..2, columns 0..2, main diagonal, anti-diagonal (priority order).
  localparam logic [CELLS-1:0] WIN_LINES [8] = '{
    9'h007, 9'h038, 9'h1C0,
    9'h049, 9'h092, 9'h124,
    9'h111, 9'h054
  };

endpackage

// File: rtl/tictactoe_board_win_detect.sv
// Combinational three-in-a-row detector for one player's marks.
// Reports the lowest-index matching entry of WIN_LINES.
module win_detect
  import tictactoe_pkg::*;
(
  input  logic [CELLS-1:0] mark,
  output logic             hit,
  output logic [CELLS-1:0] line
);

  always_comb begin
    hit  = 1'b0;
    line = '0;
    // Walk from lowest priority upward so the first line in the table wins.
    for (int i = 7; i >= 0; i--) begin
      if ((mark & WIN_LINES[i]) == WIN_LINES[i]) begin
        hit  = 1'b1;
        line = WIN_LINES[i];
      end
    end
  end

endmodule

// File: rtl/tictactoe_board.sv
// Board-state engine: validates moves, alternates players and detects
// a win or draw one cycle after each accepted move.
module tictactoe_board
  import tictactoe_pkg::*;
#(
  parameter int POS_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             move_valid,
  input  logic [POS_W-1:0] pos,
  output logic             move_ack,
  output logic             move_err,
  output logic [CELLS-1:0] cell_onehot,
  output logic [CELLS-1:0] board_x,
  output logic [CELLS-1:0] board_o,
  output logic             turn,
  output logic [1:0]       winner,
  output logic             game_over,
  output logic [CELLS-1:0] win_line
);

  state_t           state, state_nxt;
  logic             ack_nxt, err_nxt, turn_nxt, over_nxt;
  logic [CELLS-1:0] onehot_nxt, bx_nxt, bo_nxt, line_nxt;
  winner_t          winner_q, winner_nxt;

  logic [CELLS-1:0] pos_dec;
  logic             pos_ok, occupied;
  logic [CELLS-1:0] mover_mark, hit_line;
  logic             hit;

  assign pos_ok     = (pos < POS_W'(CELLS));
  assign pos_dec    = pos_ok ? (CELLS'(1) << pos) : '0;
  assign occupied   = |(pos_dec & (board_x | board_o));
  assign mover_mark = turn ? board_o : board_x;
  assign winner     = winner_q;

  win_detect u_win_detect (
    .mark (mover_mark),
    .hit  (hit),
    .line (hit_line)
  );

  always_comb begin
    state_nxt  = state;
    ack_nxt    = 1'b0;
    err_nxt    = 1'b0;
    onehot_nxt = cell_onehot;
    bx_nxt     = board_x;
    bo_nxt     = board_o;
    turn_nxt   = turn;
    winner_nxt = winner_q;
    over_nxt   = game_over;
    line_nxt   = win_line;
    if (clear) begin
      state_nxt  = PLAY;
      onehot_nxt = '0;
      bx_nxt     = '0;
      bo_nxt     = '0;
      turn_nxt   = 1'b0;
      winner_nxt = W_NONE;
      over_nxt   = 1'b0;
      line_nxt   = '0;
    end else begin
      unique case (state)
        PLAY: begin
          if (move_valid) begin
            if (pos_ok && !occupied) begin
              if (turn) bo_nxt = board_o | pos_dec;
              else      bx_nxt = board_x | pos_dec;
              onehot_nxt = pos_dec;
              ack_nxt    = 1'b1;
              state_nxt  = CHECK;
            end else begin
              err_nxt = 1'b1;
            end
          end
        end
        // Only the player who just moved can have completed a line.
        CHECK: begin
          if (hit) begin
            winner_nxt = turn ? W_O : W_X;
            line_nxt   = hit_line;
            over_nxt   = 1'b1;
            state_nxt  = DONE;
          end else if (&(board_x | board_o)) begin
            winner_nxt = W_DRAW;
            line_nxt   = '0;
            over_nxt   = 1'b1;
            state_nxt  = DONE;
          end else begin
            turn_nxt  = ~turn;
            state_nxt = PLAY;
          end
        end
        DONE: begin
          err_nxt = move_valid;
        end
        default: state_nxt = PLAY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PLAY;
      move_ack    <= 1'b0;
      move_err    <= 1'b0;
      cell_onehot <= '0;
      board_x     <= '0;
      board_o     <= '0;
      turn        <= 1'b0;
      winner_q    <= W_NONE;
      game_over   <= 1'b0;
      win_line    <= '0;
    end else begin
      state       <= state_nxt;
      move_ack    <= ack_nxt;
      move_err    <= err_nxt;
      cell_onehot <= onehot_nxt;
      board_x     <= bx_nxt;
      board_o     <= bo_nxt;
      turn        <= turn_nxt;
      winner_q    <= winner_nxt;
      game_over   <= over_nxt;
      win_line    <= line_nxt;
    end
  end

endmodule

// File: tb/tb_tictactoe_board.sv
// Directed bench for tictactoe_board with hand-computed expectations.
module tb_tictactoe_board;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       move_valid = 1'b0;
  logic [3:0] pos = '0;
  logic       move_ack, move_err, turn, game_over;
  logic [8:0] cell_onehot, board_x, board_o, win_line;
  logic [1:0] winner;

  int total = 0;
  int bad = 0;

  tictactoe_board #(.POS_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .move_valid  (move_valid),
    .pos         (pos),
    .move_ack    (move_ack),
    .move_err    (move_err),
    .cell_onehot (cell_onehot),
    .board_x     (board_x),
    .board_o     (board_o),
    .turn        (turn),
    .winner      (winner),
    .game_over   (game_over),
    .win_line    (win_line)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a move for one edge; returns with ack/err visible.
  task automatic move(input logic [3:0] p);
    move_valid = 1'b1;
    pos = p;
    tick();
    move_valid = 1'b0;
  endtask

  // Accepted move followed by its CHECK cycle.
  task automatic play(input logic [3:0] p);
    move(p);
    tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_ack", move_ack, 0);
    check("rst_err", move_err, 0);
    check("rst_bx", board_x, 0);
    check("rst_bo", board_o, 0);
    check("rst_turn", turn, 0);
    check("rst_win", {winner, game_over, win_line, cell_onehot}, 0);
    rst_n = 1'b1;
    tick();

    move(4'd4);
    check("x4_ack", {move_ack, move_err}, 2'b10);
    check("x4_bx", board_x, 9'h010);
    check("x4_onehot", cell_onehot, 9'h010);
    check("x4_turn_t1", turn, 0);
    tick();
    check("x4_turn_t2", turn, 1);
    check("x4_winner", winner, 2'b00);
    check("x4_ack_pulse", move_ack, 0);

    move(4'd4);
    check("o4_err", {move_ack, move_err}, 2'b01);
    check("o4_bo", board_o, 0);
    check("o4_turn", turn, 1);
    move(4'd11);
    check("o11_err", {move_ack, move_err}, 2'b01);
    check("o11_board", {board_x, board_o}, {9'h010, 9'h000});
    check("o11_onehot", cell_onehot, 9'h010);
    tick();
    check("err_pulse", move_err, 0);

    do_clear();
    check("clr_board", {board_x, board_o}, 0);
    check("clr_turn", turn, 0);

    play(4'd0); play(4'd3); play(4'd1); play(4'd4); play(4'd2);
    check("xwin_winner", winner, 2'b01);
    check("xwin_over", game_over, 1);
    check("xwin_line", win_line, 9'h007);
    move(4'd8);
    check("done_err", {move_ack, move_err}, 2'b01);
    check("done_frozen", {board_x, board_o}, {9'h007, 9'h018});

    do_clear();
    check("clr2_state", {winner, game_over, win_line, cell_onehot}, 0);
    play(4'd4); play(4'd0); play(4'd2); play(4'd6); play(4'd3);
    play(4'd5); play(4'd1); play(4'd7);
    check("draw_pre_over", game_over, 0);
    play(4'd8);
    check("draw_winner", winner, 2'b11);
    check("draw_over", game_over, 1);
    check("draw_line", win_line, 0);
    check("draw_full", board_x | board_o, 9'h1FF);
    check("draw_bx", board_x, 9'h11E);

    do_clear();
    move(4'd0);
    check("chk_move_ack", move_ack, 1);
    move(4'd5);
    check("chk_ignored", {move_ack, move_err}, 2'b00);
    check("chk_bo", board_o, 0);
    check("chk_turn", turn, 1);

    move_valid = 1'b1;
    pos = 4'd2;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    move_valid = 1'b0;
    check("clrmv_board", {board_x, board_o}, 0);
    check("clrmv_turn", turn, 0);
    check("clrmv_ack", {move_ack, move_err}, 2'b00);

    move(4'd0);
    check("pre_rst_ack", move_ack, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_bx", board_x, 0);
    check("async_rst_all", {move_ack, move_err, cell_onehot, turn, winner, game_over, win_line}, 0);
    #2;
    rst_n = 1'b1;
    tick();
    move(4'd0);
    check("post_rst_ack", {move_ack, move_err}, 2'b10);
    check("post_rst_bx", board_x, 9'h001);
    tick();
    check("post_rst_turn", turn, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
